// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with a one-entry holding buffer so that
// back-to-back words stream onto the serial line without idle cycles.
module serial_word_tx #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              word_done,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic [CW-1:0]     cnt;

    logic accept;
    logic last_bit;
    logic out_bit;

    assign data_ready = !hold_full && !rst;
    assign accept     = data_valid && data_ready;
    assign last_bit   = (state == S_SHIFT) && (cnt == LAST_CNT);
    assign out_bit    = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

    assign serial_out = (state == S_SHIFT) ? out_bit : IDLE_BIT;
    assign bit_valid  = (state == S_SHIFT);
    assign word_done  = last_bit;
    assign busy       = (state == S_SHIFT) || hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg <= data_in;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_bit) begin
                        // Held word wins over a fresh one; data_ready is low then anyway.
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            cnt       <= '0;
                        end else if (accept) begin
                            shreg <= data_in;
                            cnt   <= '0;
                        end else begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        if (MSB_FIRST)
                            shreg <= {shreg[DATA_W-2:0], 1'b0};
                        else
                            shreg <= {1'b0, shreg[DATA_W-1:1]};
                        cnt <= cnt + 1'b1;
                        if (accept) begin
                            hold      <= data_in;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: default 8-bit MSB-first instance plus a
// 4-bit LSB-first instance with a high idle level.
module tb_serial_word_tx;
    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, serial_out, bit_valid, word_done, busy;

    logic [3:0] d4_in;
    logic       d4_valid;
    logic       d4_ready, d4_sout, d4_bv, d4_wd, d4_busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_tx u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial_out(serial_out), .bit_valid(bit_valid),
        .word_done(word_done), .busy(busy)
    );

    serial_word_tx #(.DATA_W(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(d4_in), .data_valid(d4_valid),
        .data_ready(d4_ready), .serial_out(d4_sout), .bit_valid(d4_bv),
        .word_done(d4_wd), .busy(d4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Positioned in the first-bit cycle of w; optionally presents the next word in the last-bit cycle.
    task automatic expect_word(input logic [7:0] w, input logic nxt_v, input logic [7:0] nxt_d);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) data_valid = 1'b0;
            chk($sformatf("bit%0d_of_%h", i, w), 32'(serial_out), 32'(w[7-i]));
            chk($sformatf("bv%0d_of_%h", i, w), 32'(bit_valid), 32'd1);
            chk($sformatf("wd%0d_of_%h", i, w), 32'(word_done), (i == 7) ? 32'd1 : 32'd0);
            if (i == 7) begin
                data_valid = nxt_v;
                data_in    = nxt_d;
            end
            step();
        end
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_sout"}, 32'(serial_out), 32'd0);
        chk({tag, "_bv"},   32'(bit_valid),  32'd0);
        chk({tag, "_wd"},   32'(word_done),  32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
    endtask

    initial begin
        logic [23:0] stream_exp;
        logic [11:0] s4_exp;
        logic [7:0]  words [3];
        int idx, nb, first_c, last_c, stray;
        logic acc;

        // Reset with data_valid asserted
        rst = 1'b1; data_in = 8'hAA; data_valid = 1'b1; d4_in = 4'h0; d4_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step();
            expect_idle($sformatf("rst%0d", r));
            chk("rst_ready", 32'(data_ready), 32'd0);
            chk("rst_d4_sout", 32'(d4_sout), 32'd1);
        end
        rst = 1'b0; data_valid = 1'b0;
        #1;
        chk("post_rst_ready", 32'(data_ready), 32'd1);

        // Single word 0xD0
        data_in = 8'hD0; data_valid = 1'b1;
        step();
        chk("single_ready_shift", 32'(data_ready), 32'd1);
        expect_word(8'hD0, 1'b0, 8'h00);
        expect_idle("single_end");

        // Streaming A5, 3C, FF with valid held high
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        stream_exp = 24'hA53CFF;
        idx = 0; nb = 0; first_c = -1; last_c = -1;
        data_in = words[0]; data_valid = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            acc = data_valid && data_ready;
            step();
            if (acc) begin
                idx++;
                if (idx == 1) chk("stream_ready_after1", 32'(data_ready), 32'd1);
                if (idx == 2) chk("stream_ready_after2", 32'(data_ready), 32'd0);
                if (idx < 3) data_in = words[idx];
                else data_valid = 1'b0;
            end
            if (bit_valid) begin
                if (nb < 24) chk($sformatf("stream_bit%0d", nb), 32'(serial_out), 32'(stream_exp[23-nb]));
                if (first_c < 0) first_c = c;
                last_c = c;
                nb++;
            end
        end
        chk("stream_nbits", nb, 24);
        chk("stream_contig", last_c - first_c + 1, 24);
        expect_idle("stream_end");

        // Bypass: 0x80 offered first in the last-bit cycle of 0x0F
        data_in = 8'h0F; data_valid = 1'b1;
        step();
        expect_word(8'h0F, 1'b1, 8'h80);
        expect_word(8'h80, 1'b0, 8'h00);
        expect_idle("bypass_end");

        // Reset mid-word with a full holding buffer
        data_in = 8'hC3; data_valid = 1'b1;
        step();
        data_in = 8'h5A;
        step();
        data_valid = 1'b0;
        chk("mid_hold_ready", 32'(data_ready), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        step();
        chk("mid_bit2", 32'(serial_out), 32'd0);
        rst = 1'b1;
        step();
        expect_idle("mid_rst");
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bit_valid || busy || serial_out) stray++;
        end
        chk("mid_no_stray_bits", stray, 0);

        // 4-bit LSB-first instance with backpressure: words 1, 2, then B (E never accepted)
        s4_exp = 12'b1000_0100_1101;
        nb = 0;
        d4_in = 4'h1; d4_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 1) d4_in = 4'h2;
            if (c == 2) begin chk("d4_ready_c2", 32'(d4_ready), 32'd0); d4_in = 4'hE; end
            if (c == 3) d4_in = 4'hB;
            if (c == 4) chk("d4_ready_c4", 32'(d4_ready), 32'd0);
            if (c == 5) chk("d4_ready_c5", 32'(d4_ready), 32'd1);
            if (c == 6) d4_valid = 1'b0;
            if (c <= 12) begin
                chk($sformatf("d4_bv%0d", c), 32'(d4_bv), 32'd1);
                chk($sformatf("d4_bit%0d", c), 32'(d4_sout), 32'(s4_exp[12-c]));
                chk($sformatf("d4_wd%0d", c), 32'(d4_wd), (c % 4 == 0) ? 32'd1 : 32'd0);
            end else begin
                chk($sformatf("d4_idle_bv%0d", c), 32'(d4_bv), 32'd0);
                chk($sformatf("d4_idle_sout%0d", c), 32'(d4_sout), 32'd1);
            end
        end
        chk("d4_busy_end", 32'(d4_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial front end for the serial sequence-detector stage. Accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on a serial line that drives the detector's serial input directly. A one-entry holding buffer lets consecutive words stream with no idle cycles between them.

## Interface
- DATA_W, default 8: word width in bits. Must be 2 or greater.
- MSB_FIRST, default 1: when 1, bit DATA_W-1 is sent first; when 0, bit 0 is sent first.
- IDLE_BIT, default 0: level driven on serial_out when no word is being sent.
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, DATA_W: word to be serialized.
- data_valid, input, 1: data_in is valid.
- data_ready, output, 1: block can accept a word this cycle.
- serial_out, output, 1: serial bit stream (connects to the detector input).
- bit_valid, output, 1: serial_out carries a word bit this cycle.
- word_done, output, 1: this cycle carries the last bit of a word.
- busy, output, 1: a word is shifting or the holding buffer is full.

## Operation
- Storage:
  - shift register shreg[DATA_W-1:0];
  - bit counter cnt of width clog2(DATA_W), counting 0..DATA_W-1;
  - holding register hold plus flag hold_full;
  - state register with states IDLE and SHIFT.
- Accept: a word is accepted at a rising edge when data_valid and data_ready are both 1.
- data_ready = !hold_full && !rst. It is combinational from registers and rst only, never from data_valid.
- IDLE:
  - serial_out = IDLE_BIT; bit_valid = 0; word_done = 0.
  - On accept: shreg <= data_in, cnt <= 0, state goes to SHIFT.
- SHIFT:
  - serial_out is shreg[DATA_W-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); bit_valid = 1.
  - Each edge: shreg shifts toward the output end, cnt increments.
- Last-bit cycle (cnt == DATA_W-1): word_done = 1. At the next edge, the first matching rule applies:
  - hold_full: shreg <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT.
  - Accept this edge: shreg <= data_in directly (bypass), cnt <= 0, stay in SHIFT.
  - Otherwise: go to IDLE.
- Accept while in SHIFT and not in the last-bit cycle: hold <= data_in, hold_full <= 1.
- Only one word moves per edge. data_ready = 0 whenever hold_full = 1, so hold never overflows.
- busy = (state == SHIFT) || hold_full.
- Words are transmitted in acceptance order. No word is dropped or duplicated.

## Timing
- Reset (rst = 1 at an edge):
  - state <= IDLE, hold_full <= 0, cnt <= 0, shreg <= 0.
  - Outputs after that edge: serial_out = IDLE_BIT, bit_valid = 0, word_done = 0, busy = 0.
  - data_ready = 0 while rst = 1; it is 1 in the first cycle after rst deasserts.
- Reset mid-operation: any word in flight and any held word are discarded. No further bits of either appear.
- Latency: a word accepted at edge k from IDLE puts its first bit on serial_out in cycle k+1 and its last bit in cycle k+DATA_W. word_done = 1 in cycle k+DATA_W. The block returns to IDLE in cycle k+DATA_W+1 if no further word is available.
- Throughput: with data_valid held high, bit_valid stays 1 continuously with one bit per cycle and no gaps at word boundaries.
- A word accepted during the last-bit cycle starts in the immediately following cycle (bypass), with zero gap.
- While data_ready = 0, data_in and data_valid are ignored. The sender must hold its word until it is accepted.
- All outputs are glitch-free functions of registers. serial_out and bit_valid do not depend combinationally on any input.

## Test plan
- Reset: hold rst = 1 for 2 cycles with data_valid = 1 -> serial_out = 0, bit_valid = 0, busy = 0, data_ready = 0 during reset and 1 in the first cycle after.
- Single word: 8'hD0 accepted at edge k -> serial_out = 1,1,0,1,0,0,0,0 in cycles k+1..k+8, bit_valid high for exactly 8 cycles, word_done only in cycle k+8, IDLE in cycle k+9. The downstream detector flags the 1101 pattern.
- Streaming: 8'hA5, 8'h3C, 8'hFF presented with data_valid held high -> data_ready drops after the second accept, 24 contiguous bit_valid cycles, bit order 10100101 00111100 11111111.
- Bypass: data_valid first asserted (hold empty) exactly in the last-bit cycle of 8'h0F, with data_in = 8'h80 -> serial_out = 1 in the very next cycle, no gap.
- Reset mid-word: rst asserted after 3 bits with hold_full = 1 -> next cycle shows idle outputs, busy = 0, and no bits of either discarded word appear afterwards.
- Parameters and backpressure: DATA_W = 4, MSB_FIRST = 0, IDLE_BIT = 1; data_in changes while data_ready = 0 -> only the word present at the accepting edge is sent, LSB first, and serial_out = 1 when idle.
